// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic EX->MEM pipeline register with STAGES slots and a valid/ready
//   handshake. Entries advance into empty downstream slots even while the
//   consumer stalls, so bubbles close up. A flush squashes every in-flight
//   entry. Saturating counters record stall and flush cycles.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   in_valid_i / in_ready_o      upstream handshake
//   alu_res_i, wr_data_i,
//   rd_addr_i, ctrl_i            incoming payload
//   flush_i                      squash all entries on this edge
//   out_valid_o / out_ready_i    downstream handshake
//   alu_res_o, wr_data_o,
//   rd_addr_o, ctrl_o            last-slot payload (ctrl_o zero when invalid)
//   occupancy_o                  registered count of valid slots
//   stall_cnt_o, flush_cnt_o     saturating performance counters
module pipe_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 4,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] alu_res_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [2:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] alu_res_q [STAGES];
  logic [DATA_W-1:0] alu_res_d [STAGES];
  logic [DATA_W-1:0] wr_data_q [STAGES];
  logic [DATA_W-1:0] wr_data_d [STAGES];
  logic [ADDR_W-1:0] rd_addr_q [STAGES];
  logic [ADDR_W-1:0] rd_addr_d [STAGES];
  logic [CTRL_W-1:0] ctrl_q    [STAGES];
  logic [CTRL_W-1:0] ctrl_d    [STAGES];
  logic [2:0]        occupancy_q, occupancy_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  // mv[k] means slot k hands its entry onward this cycle.
  logic [STAGES-1:0] mv;
  logic              in_ready;
  logic              accept;

  // Move chain resolved from the output end backwards: a slot can take a new
  // entry if it is empty or its own entry is leaving.
  always_comb begin
    mv = '0;
    mv[STAGES-1] = valid_q[STAGES-1] & out_ready_i;
    for (int k = STAGES - 1; k >= 1; k--) begin
      mv[k-1] = valid_q[k-1] & (~valid_q[k] | mv[k]);
    end
    // Flush discards whatever is accepted, so upstream is never held off.
    in_ready = ~valid_q[0] | mv[0] | flush_i;
    accept   = in_valid_i & in_ready;
  end

  // Next state: a slot that loads takes its upstream payload; a slot that is
  // vacated without a replacement drops its valid bit but keeps its payload.
  always_comb begin
    valid_d   = valid_q;
    alu_res_d = alu_res_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    ctrl_d    = ctrl_q;

    if (accept) begin
      valid_d[0]   = 1'b1;
      alu_res_d[0] = alu_res_i;
      wr_data_d[0] = wr_data_i;
      rd_addr_d[0] = rd_addr_i;
      ctrl_d[0]    = ctrl_i;
    end else if (mv[0]) begin
      valid_d[0] = 1'b0;
    end

    for (int k = 1; k < STAGES; k++) begin
      if (mv[k-1]) begin
        valid_d[k]   = 1'b1;
        alu_res_d[k] = alu_res_q[k-1];
        wr_data_d[k] = wr_data_q[k-1];
        rd_addr_d[k] = rd_addr_q[k-1];
        ctrl_d[k]    = ctrl_q[k-1];
      end else if (mv[k]) begin
        valid_d[k] = 1'b0;
      end
    end

    if (flush_i) begin
      valid_d = '0;
    end

    occupancy_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy_d = occupancy_d + 3'(valid_d[k]);
    end

    stall_cnt_d = stall_cnt_q;
    if (valid_q[STAGES-1] && !out_ready_i && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    flush_cnt_d = flush_cnt_q;
    if (flush_i && flush_cnt_q != '1) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      occupancy_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        alu_res_q[k] <= '0;
        wr_data_q[k] <= '0;
        rd_addr_q[k] <= '0;
        ctrl_q[k]    <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      occupancy_q <= occupancy_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      for (int k = 0; k < STAGES; k++) begin
        alu_res_q[k] <= alu_res_d[k];
        wr_data_q[k] <= wr_data_d[k];
        rd_addr_q[k] <= rd_addr_d[k];
        ctrl_q[k]    <= ctrl_d[k];
      end
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = valid_q[STAGES-1];
  assign alu_res_o   = alu_res_q[STAGES-1];
  assign wr_data_o   = wr_data_q[STAGES-1];
  assign rd_addr_o   = rd_addr_q[STAGES-1];
  assign ctrl_o      = valid_q[STAGES-1] ? ctrl_q[STAGES-1] : '0;
  assign occupancy_o = occupancy_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic
//   Directed bench for pipe_stage_elastic. Instance "a" uses STAGES=2 with a
//   4-bit counter width; instance "b" uses STAGES=3 with 16-bit counters.
//   Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_pipe_stage_elastic;

  logic clk;
  logic rst;

  // Instance a: STAGES=2, CNT_W=4
  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [31:0] a_alu_i, a_wr_i, a_alu_o, a_wr_o;
  logic [4:0]  a_rd_i, a_rd_o;
  logic [3:0]  a_ctrl_i, a_ctrl_o;
  logic [2:0]  a_occ;
  logic [3:0]  a_stall, a_fcnt;

  // Instance b: STAGES=3, CNT_W=16
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [31:0] b_alu_i, b_wr_i, b_alu_o, b_wr_o;
  logic [4:0]  b_rd_i, b_rd_o;
  logic [3:0]  b_ctrl_i, b_ctrl_o;
  logic [2:0]  b_occ;
  logic [15:0] b_stall, b_fcnt;

  int vectors;
  int miscompares;

  pipe_stage_elastic #(.STAGES(2), .CNT_W(4)) u_a (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .alu_res_i(a_alu_i), .wr_data_i(a_wr_i), .rd_addr_i(a_rd_i), .ctrl_i(a_ctrl_i),
    .flush_i(a_flush),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .alu_res_o(a_alu_o), .wr_data_o(a_wr_o), .rd_addr_o(a_rd_o), .ctrl_o(a_ctrl_o),
    .occupancy_o(a_occ), .stall_cnt_o(a_stall), .flush_cnt_o(a_fcnt)
  );

  pipe_stage_elastic #(.STAGES(3), .CNT_W(16)) u_b (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .alu_res_i(b_alu_i), .wr_data_i(b_wr_i), .rd_addr_i(b_rd_i), .ctrl_i(b_ctrl_i),
    .flush_i(b_flush),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .alu_res_o(b_alu_o), .wr_data_o(b_wr_o), .rd_addr_o(b_rd_o), .ctrl_o(b_ctrl_o),
    .occupancy_o(b_occ), .stall_cnt_o(b_stall), .flush_cnt_o(b_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Payload fields are derived from the ALU value so one number identifies an entry.
  task automatic a_drive(input logic v, input logic [31:0] val);
    a_in_valid = v;
    a_alu_i    = val;
    a_wr_i     = ~val;
    a_rd_i     = val[4:0];
    a_ctrl_i   = val[3:0] | 4'h1;
  endtask

  task automatic b_drive(input logic v, input logic [31:0] val);
    b_in_valid = v;
    b_alu_i    = val;
    b_wr_i     = ~val;
    b_rd_i     = val[4:0];
    b_ctrl_i   = val[3:0] | 4'h1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    a_drive(1'b0, 32'h0);
    b_drive(1'b0, 32'h0);
    a_flush     = 1'b0;
    b_flush     = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;

    // ---- reset state ----
    #3;
    chk("rst_out_valid", {31'b0, a_out_valid}, 32'h0);
    chk("rst_in_ready", {31'b0, a_in_ready}, 32'h1);
    chk("rst_occ", {29'b0, a_occ}, 32'h0);
    chk("rst_alu", a_alu_o, 32'h0);
    tick();
    rst = 1'b0;

    // ---- latency / throughput, STAGES=2 ----
    a_drive(1'b1, 32'h11);
    tick();
    a_drive(1'b1, 32'h22);
    chk("lat_not_yet", {31'b0, a_out_valid}, 32'h0);
    tick();
    a_drive(1'b1, 32'h33);
    chk("lat_valid", {31'b0, a_out_valid}, 32'h1);
    chk("lat_out0", a_alu_o, 32'h11);
    chk("lat_wr0", a_wr_o, ~32'h11);
    chk("lat_ctrl0", {28'b0, a_ctrl_o}, 32'h1);
    chk("lat_occ_full", {29'b0, a_occ}, 32'h2);
    tick();
    a_drive(1'b0, 32'h0);
    chk("thr_out1", a_alu_o, 32'h22);
    chk("thr_occ_keep", {29'b0, a_occ}, 32'h2);
    tick();
    chk("thr_out2", a_alu_o, 32'h33);
    chk("thr_rd2", {27'b0, a_rd_o}, 32'h13);
    chk("thr_valid2", {31'b0, a_out_valid}, 32'h1);
    tick();
    chk("drain_valid", {31'b0, a_out_valid}, 32'h0);
    chk("drain_ctrl_gated", {28'b0, a_ctrl_o}, 32'h0);
    chk("drain_payload_held", a_alu_o, 32'h33);
    chk("drain_occ", {29'b0, a_occ}, 32'h0);

    // ---- backpressure + saturation, STAGES=2, CNT_W=4 ----
    a_out_ready = 1'b0;
    a_drive(1'b1, 32'hA1);
    tick();
    a_drive(1'b1, 32'hA2);
    tick();
    a_drive(1'b1, 32'hCC);
    #1;
    chk("bp_in_ready", {31'b0, a_in_ready}, 32'h0);
    tick();
    chk("bp_alu_hold", a_alu_o, 32'hA1);
    chk("bp_occ", {29'b0, a_occ}, 32'h2);
    chk("bp_stall1", {28'b0, a_stall}, 32'h1);
    tick();
    chk("bp_stall2", {28'b0, a_stall}, 32'h2);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", {28'b0, a_stall}, 32'hF);
    tick();
    chk("sat_nowrap", {28'b0, a_stall}, 32'hF);
    chk("sat_alu_hold", a_alu_o, 32'hA1);

    // ---- flush with simultaneous accept and output transfer ----
    a_out_ready = 1'b1;
    a_flush     = 1'b1;
    a_drive(1'b1, 32'hDD);
    #1;
    chk("fl_in_ready", {31'b0, a_in_ready}, 32'h1);
    chk("fl_out_consumed", a_alu_o, 32'hA1);
    tick();
    a_flush = 1'b0;
    a_drive(1'b0, 32'h0);
    chk("fl_valid", {31'b0, a_out_valid}, 32'h0);
    chk("fl_ctrl", {28'b0, a_ctrl_o}, 32'h0);
    chk("fl_occ", {29'b0, a_occ}, 32'h0);
    chk("fl_cnt", {28'b0, a_fcnt}, 32'h1);
    chk("fl_stall_kept", {28'b0, a_stall}, 32'hF);
    tick();
    chk("fl_d_dropped", {31'b0, a_out_valid}, 32'h0);
    chk("fl_occ2", {29'b0, a_occ}, 32'h0);

    // ---- asynchronous reset mid-stream, STAGES=2 ----
    a_out_ready = 1'b0;
    a_drive(1'b1, 32'h55);
    tick();
    a_drive(1'b1, 32'h66);
    tick();
    a_drive(1'b0, 32'h0);
    chk("mr_occ_before", {29'b0, a_occ}, 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_valid", {31'b0, a_out_valid}, 32'h0);
    chk("mr_alu", a_alu_o, 32'h0);
    chk("mr_wr", a_wr_o, 32'h0);
    chk("mr_occ", {29'b0, a_occ}, 32'h0);
    chk("mr_in_ready", {31'b0, a_in_ready}, 32'h1);
    chk("mr_stall", {28'b0, a_stall}, 32'h0);
    chk("mr_fcnt", {28'b0, a_fcnt}, 32'h0);
    #2;
    rst = 1'b0;
    a_out_ready = 1'b1;
    a_drive(1'b1, 32'h77);
    tick();
    a_drive(1'b0, 32'h0);
    tick();
    chk("mr_recover", a_alu_o, 32'h77);
    chk("mr_recover_occ", {29'b0, a_occ}, 32'h1);

    // ---- latency, STAGES=3 ----
    b_drive(1'b1, 32'hE0);
    tick();
    b_drive(1'b0, 32'h0);
    tick();
    chk("b_lat_2", {31'b0, b_out_valid}, 32'h0);
    tick();
    chk("b_lat_3", {31'b0, b_out_valid}, 32'h1);
    chk("b_lat_alu", b_alu_o, 32'hE0);
    tick();
    chk("b_lat_empty", {29'b0, b_occ}, 32'h0);

    // ---- stall with bubble collapse, STAGES=3 ----
    b_out_ready = 1'b0;
    b_drive(1'b1, 32'h0A);
    tick();
    b_drive(1'b0, 32'h0);
    tick();
    b_drive(1'b1, 32'h0B);
    tick();
    b_drive(1'b0, 32'h0);
    tick();
    chk("bc_out_a", b_alu_o, 32'h0A);
    chk("bc_occ", {29'b0, b_occ}, 32'h2);
    chk("bc_stall1", {16'b0, b_stall}, 32'h1);
    tick();
    chk("bc_stall2", {16'b0, b_stall}, 32'h2);
    b_out_ready = 1'b1;
    #1;
    chk("bc_in_ready", {31'b0, b_in_ready}, 32'h1);
    tick();
    chk("bc_out_b", b_alu_o, 32'h0B);
    chk("bc_out_b_valid", {31'b0, b_out_valid}, 32'h1);
    chk("bc_occ1", {29'b0, b_occ}, 32'h1);
    chk("bc_stall_kept", {16'b0, b_stall}, 32'h2);
    tick();
    chk("bc_drained", {31'b0, b_out_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
